// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor.
//   NIBBLE_W : width of one digit handled per clock by the shared adder
//   state_t  : controller state encoding (IDLE / RUN / DONE)
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_adder4bits.sv
// Existing 4-bit ripple adder reused by the serial controller.
// Ports:
//   A, B  : 4-bit addends
//   Cin   : carry in
//   Sum   : 4-bit sum
//   Cout  : carry out
module adder4bits
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] A,
  input  logic [NIBBLE_W-1:0] B,
  input  logic                Cin,
  output logic [NIBBLE_W-1:0] Sum,
  output logic                Cout
);

  logic [NIBBLE_W:0] w_full;

  assign w_full = {1'b0, A} + {1'b0, B} + {{NIBBLE_W{1'b0}}, Cin};
  assign Sum    = w_full[NIBBLE_W-1:0];
  assign Cout   = w_full[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder/subtractor: W = 4*NIBBLES bit operands are processed one
// nibble per clock, LSB first, through a single adder4bits instance.
// Ports:
//   clk, rst_n        : clock (rising edge), async active-low reset
//   i_start           : begin an operation (accepted in IDLE or DONE only)
//   i_sub             : 0 = A + B + cin, 1 = A - B
//   i_cin             : carry in for add mode
//   i_op_a, i_op_b    : operands, sampled on the accepting edge
//   o_busy            : high while nibbles are processed
//   o_done            : one-cycle pulse when the result is valid
//   o_sum, o_cout     : result and final carry (sub: 1 = no borrow)
//   o_ovf             : two's-complement signed overflow
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one nibble added per cycle, carry kept in r_carry
// DONE  | result valid for one cycle; a new start is accepted here
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic                      i_sub,
  input  logic                      i_cin,
  input  logic [4*NIBBLES-1:0]      i_op_a,
  input  logic [4*NIBBLES-1:0]      i_op_b,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [4*NIBBLES-1:0]      o_sum,
  output logic                      o_cout,
  output logic                      o_ovf
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t             r_state;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_part;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;

  logic [NIBBLE_W-1:0] w_nib_a;
  logic [NIBBLE_W-1:0] w_nib_b;
  logic [NIBBLE_W-1:0] w_nib_sum;
  logic                w_nib_cout;
  logic [W-1:0]        w_part_next;

  assign w_nib_a = r_a[int'(r_idx)*NIBBLE_W +: NIBBLE_W];
  assign w_nib_b = r_b[int'(r_idx)*NIBBLE_W +: NIBBLE_W];

  adder4bits u_adder (
    .A    (w_nib_a),
    .B    (w_nib_b),
    .Cin  (r_carry),
    .Sum  (w_nib_sum),
    .Cout (w_nib_cout)
  );

  // Partial result with the current nibble merged in, so the final load
  // into o_sum already contains the last digit.
  always_comb begin
    w_part_next = r_part;
    w_part_next[int'(r_idx)*NIBBLE_W +: NIBBLE_W] = w_nib_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_sum   <= '0;
      o_cout  <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_a     <= i_op_a;
            // Subtraction as A + ~B + 1; cin is ignored in that mode.
            r_b     <= i_sub ? ~i_op_b : i_op_b;
            r_carry <= i_sub ? 1'b1 : i_cin;
            r_idx   <= '0;
            r_state <= RUN;
            o_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_part  <= w_part_next;
          r_carry <= w_nib_cout;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == IDX_LAST) begin
            r_state <= DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            o_sum   <= w_part_next;
            o_cout  <= w_nib_cout;
            // Overflow judged against the effective (possibly inverted) B.
            o_ovf   <= (r_a[W-1] == r_b[W-1]) && (w_part_next[W-1] != r_a[W-1]);
          end
        end
        default: begin
          r_state <= IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_asserts;
  int n_fail;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (start),
    .i_sub   (sub),
    .i_cin   (cin),
    .i_op_a  (op_a),
    .i_op_b  (op_b),
    .o_busy  (busy),
    .o_done  (done),
    .o_sum   (sum),
    .o_cout  (cout),
    .o_ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one start pulse, scrambles the operands afterwards, and waits
  // (bounded) for done. lat = negedges after the accepting edge until done.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s,
                       output int lat, output int busy_cnt);
    @(negedge clk);
    op_a = a; op_b = b; cin = c; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_a = W'($urandom());
    op_b = W'($urandom());
    cin  = 1'($urandom());
    sub  = 1'($urandom());
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    n_asserts++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b required all 0",
               busy, done, sum, cout, ovf);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_asserts++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_add();
    int lat, bc;
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat, bc);
    n_asserts++;
    if (lat !== 4 || bc !== 4) begin
      n_fail++;
      $display("FAIL add_timing: got lat=%0d busy_cycles=%0d required 4 4", lat, bc);
    end
    n_asserts++;
    if (sum !== 16'h5555 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL add_result: got sum=%h cout=%b ovf=%b required 5555 0 0", sum, cout, ovf);
    end
    @(negedge clk);
    n_asserts++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== 16'h5555) begin
      n_fail++;
      $display("FAIL add_after: got done=%b busy=%b sum=%h required 0 0 5555", done, busy, sum);
    end
  endtask

  task automatic test_carry();
    int lat, bc;
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bc);
    n_asserts++;
    if (sum !== 16'h0000 || cout !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL carry_b: got sum=%h cout=%b ovf=%b required 0000 1 0", sum, cout, ovf);
    end
    do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, lat, bc);
    n_asserts++;
    if (lat !== 4 || sum !== 16'h0000 || cout !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL carry_cin: got lat=%0d sum=%h cout=%b ovf=%b required 4 0000 1 0",
               lat, sum, cout, ovf);
    end
  endtask

  task automatic test_sub();
    int lat, bc;
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, lat, bc);
    n_asserts++;
    if (sum !== 16'hFFFE || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_borrow: got sum=%h cout=%b ovf=%b required fffe 0 0", sum, cout, ovf);
    end
    do_op(16'h0007, 16'h0005, 1'b0, 1'b1, lat, bc);
    n_asserts++;
    if (sum !== 16'h0002 || cout !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_noborrow: got sum=%h cout=%b ovf=%b required 0002 1 0", sum, cout, ovf);
    end
  endtask

  task automatic test_ovf();
    int lat, bc;
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, bc);
    n_asserts++;
    if (sum !== 16'h8000 || cout !== 1'b0 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_add: got sum=%h cout=%b ovf=%b required 8000 0 1", sum, cout, ovf);
    end
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat, bc);
    n_asserts++;
    if (sum !== 16'h7FFF || cout !== 1'b1 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sub: got sum=%h cout=%b ovf=%b required 7fff 1 1", sum, cout, ovf);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    op_a = 16'h0F0F; op_b = 16'h0101; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_asserts++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got busy=%b done=%b sum=%h cout=%b ovf=%b required all 0",
               busy, done, sum, cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_asserts++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_done cycle %0d: got done=%b busy=%b required 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_start_during_run();
    int lat;
    @(negedge clk);
    op_a = 16'h1111; op_b = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    op_a = 16'h0F0F; op_b = 16'h0F0F; sub = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 2;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_asserts++;
    if (lat !== 4 || sum !== 16'h3333 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_run: got lat=%0d sum=%h cout=%b required 4 3333 0", lat, sum, cout);
    end
    @(negedge clk);
    n_asserts++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_not_queued: got busy=%b required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int n, m;
    @(negedge clk);
    op_a = 16'h0001; op_b = 16'h0002; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    op_a = 16'h0010; op_b = 16'h0020;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_asserts++;
    if (n !== 4 || sum !== 16'h0003) begin
      n_fail++;
      $display("FAIL b2b_first: got lat=%0d sum=%h required 4 0003", n, sum);
    end
    @(negedge clk);
    start = 1'b0;
    n_asserts++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_idle: got busy=%b done=%b required 1 0", busy, done);
    end
    m = 1;
    while (!done && m < 20) begin
      @(negedge clk);
      m++;
    end
    n_asserts++;
    if (m !== 5 || sum !== 16'h0030) begin
      n_fail++;
      $display("FAIL b2b_second: got spacing=%0d sum=%h required 5 0030", m, sum);
    end
  endtask

  initial begin
    n_asserts = 0;
    n_fail = 0;
    test_reset();
    test_add();
    test_carry();
    test_sub();
    test_ovf();
    test_reset_mid_run();
    test_start_during_run();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle adder/subtractor for operands of 4*NIBBLES bits.
- Reuses one adder4bits instance, one nibble per clock, LSB nibble first; carry is registered between nibbles.
- Sits around the 4-bit adder: it sequences operand nibbles into the adder and collects its Sum/Cout.
- Start/busy/done handshake toward the controlling logic.

Parameters:
- NIBBLES, 4, number of 4-bit digits processed; data width W = 4*NIBBLES; legal range 1..8.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset
- start  input  1  request a new operation; sampled only in IDLE or DONE
- sub  input  1  0 = add (A + B + cin), 1 = subtract (A - B; cin ignored)
- cin  input  1  carry-in for add mode
- op_a  input  W  operand A, sampled with start
- op_b  input  W  operand B, sampled with start
- busy  output  1  high while nibbles are being processed
- done  output  1  one-cycle pulse when the result is valid
- sum  output  W  result, held until the next completion
- cout  output  1  final carry out; in sub mode 1 = no borrow
- ovf  output  1  two's-complement signed overflow of the result

Interface (already decided):
- One clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal operand, carry, index and partial-result registers cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1, on that edge:
  - latch a_reg=op_a;
  - latch b_reg=op_b, or ~op_b when sub=1;
  - set carry_reg = sub ? 1 : cin; idx=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - adder inputs: A=a_reg[4*idx+3:4*idx], B=b_reg nibble idx, Cin=carry_reg (combinational through adder4bits).
  - on the edge: partial-result nibble idx = Sum; carry_reg = Cout; idx increments.
  - When idx==NIBBLES-1 on that edge, the FSM goes to DONE and loads the outputs:
    - sum = full partial result, including this last nibble;
    - cout = last Cout;
    - ovf = (a_reg[W-1] == b_reg[W-1]) && (sum[W-1] != a_reg[W-1]), using the effective (possibly inverted) b_reg.
- DONE: lasts one cycle with done=1.
  - If start=1 in this cycle, accept it exactly as in IDLE and go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- busy=1 exactly in RUN cycles. done=1 exactly in DONE cycles.
- Latency: start sampled at edge k gives busy high for NIBBLES cycles, then done high for the cycle after edge k+NIBBLES.
- start while in RUN is ignored; it is not queued.
- Operand inputs are don't-care except on the accepting edge.
- sum/cout/ovf change only on the RUN->DONE transition; they hold their value through IDLE and the next RUN.
- Asserting reset mid-RUN aborts immediately: no done pulse, outputs cleared.
- NIBBLES=1: a single RUN cycle, then DONE.
- All arithmetic is modulo 2^W; carry/borrow is visible only on cout.

Decomposition:
- Shared package/header:
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - a NIBBLE_W=4 constant.
- Index register width: clog2(NIBBLES) rounded up to at least 1.
- Sub-module: the existing adder4bits, instantiated once. No other sub-modules.
- Nibble select and partial-result write use indexed part-select driven by idx.

Test Plan (NIBBLES=4):
- Add: op_a=16'h1234, op_b=16'h4321, cin=0, sub=0, start one cycle -> busy 4 cycles, done 1 cycle; sum=16'h5555, cout=0, ovf=0.
- Carry chain: op_a=16'hFFFF, op_b=16'h0001, cin=0 -> sum=16'h0000, cout=1, ovf=0.
  - Repeat with op_b=16'h0000, cin=1 -> same result.
- Subtract: op_a=16'h0005, op_b=16'h0007, sub=1, cin=1 (must be ignored) -> sum=16'hFFFE, cout=0, ovf=0.
  - op_a=16'h0007, op_b=16'h0005 -> sum=16'h0002, cout=1.
- Overflow:
  - 16'h7FFF + 16'h0001 -> sum=16'h8000, ovf=1;
  - sub 16'h8000 - 16'h0001 -> sum=16'h7FFF, ovf=1, cout=1.
- Handshake:
  - start pulses during RUN are ignored; the result matches the first operands.
  - start held high through DONE -> a second operation begins with no IDLE cycle, and done pulses again 5 cycles after the first.
- Reset: drop rst_n asynchronously mid-RUN (between edges) -> busy/done/sum/cout/ovf go 0 immediately; after release, state is IDLE and no done pulse appears until a new start.
